// File: rtl/seg_pattern_encoder_if.sv
// Display readback bus: multiplexed digit select and segment byte in, decoded digits out.
// The master drives an/seg and observes results; the slave is the encoder.
// Output fields are registered inside the encoder; this file carries no logic.
`timescale 1ns/1ps
interface seg_pattern_encoder_if #(
  parameter int NDIG = 4
);
  logic [NDIG-1:0]   an;
  logic [7:0]        seg;
  logic [4*NDIG-1:0] digits_out;
  logic [NDIG-1:0]   dp_out;
  logic [NDIG-1:0]   valid_out;
  logic              frame_done;
  logic              err;

  modport master (
    output an, seg,
    input  digits_out, dp_out, valid_out, frame_done, err
  );

  modport slave (
    input  an, seg,
    output digits_out, dp_out, valid_out, frame_done, err
  );
endinterface

// File: rtl/seg_pattern_encoder.sv
// Reads the multiplexed 7-segment bus back into per-digit hex nibbles with decimal points.
// Latency: {an,seg} stable before edge t0 -> outputs update at edge t0+STABLE_CYC.
// No backpressure: a passive monitor that samples every cycle and never stalls the display.
`timescale 1ns/1ps
module seg_pattern_encoder #(
  parameter int NDIG           = 4,
  parameter int STABLE_CYC     = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_pattern_encoder_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_CAPT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [NDIG-1:0]   r_an;
  logic [7:0]        r_seg;
  logic [CW-1:0]     r_cnt;
  state_t            r_state;
  logic [4*NDIG-1:0] r_digits;
  logic [NDIG-1:0]   r_dp;
  logic [NDIG-1:0]   r_valid;
  logic [NDIG-1:0]   r_seen;
  logic              r_frame_done;
  logic              r_err;

  logic              w_chg;
  logic [CW-1:0]     w_cnt_nxt;
  state_t            w_state_nxt;
  logic              w_capt;
  logic [7:0]        w_seg_eff;
  logic [3:0]        w_nib;
  logic              w_legal;
  logic              w_blank;
  logic              w_multi;
  logic [NDIG-1:0]   w_cm;
  logic              w_full;

  // Any difference between the pins and the last registered sample restarts stability counting.
  assign w_chg     = ({bus.an, bus.seg} != {r_an, r_seg});
  // Decoding always works on lit=1 polarity regardless of the pin polarity.
  assign w_seg_eff = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
  assign w_blank   = (w_seg_eff[6:0] == 7'h00);
  assign w_multi   = ((r_an & (r_an - NDIG'(1))) != '0);
  // Digits touched by this capture; multi-hot slots update nothing.
  assign w_cm      = (w_capt && !w_multi) ? r_an : '0;
  assign w_full    = &r_seen;

  // Register the raw pins; every decision is made on the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '0;
      r_seg <= '0;
    end else begin
      r_an  <= bus.an;
      r_seg <= bus.seg;
    end
  end

  // Stability count: cleared on change, otherwise counts up and saturates at STABLE_CYC.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_chg) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CW'(STABLE_CYC)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Counter and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= S_WAIT;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Next state: enter CAPT exactly once per stable run; a change during CAPT still captures.
  always_comb begin
    w_state_nxt = r_state;
    w_capt      = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (!w_chg && (w_cnt_nxt == CW'(STABLE_CYC - 1))) begin
          w_state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = w_chg ? S_WAIT : S_HOLD;
      end
      S_HOLD: begin
        if (w_chg) begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Glyph table lookup; the decimal point bit never takes part in the match.
  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    case (w_seg_eff[6:0])
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Per-digit capture: legal glyph loads nibble+dp, blank keeps nibble but loads dp, junk only drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_valid  <= '0;
    end else if (w_capt && !w_multi) begin
      for (int i = 0; i < NDIG; i++) begin
        if (r_an[i]) begin
          if (w_legal) begin
            r_digits[4*i +: 4] <= w_nib;
            r_dp[i]            <= w_seg_eff[7];
            r_valid[i]         <= 1'b1;
          end else begin
            r_valid[i] <= 1'b0;
            if (w_blank) begin
              r_dp[i] <= w_seg_eff[7];
            end
          end
        end
      end
    end
  end

  // Frame tracking and event pulses; a full mask restarts with this cycle's capture already recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen       <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_seen       <= w_full ? w_cm : (r_seen | w_cm);
      r_frame_done <= w_full;
      r_err        <= w_capt && (r_an != '0) && (w_multi || (!w_legal && !w_blank));
    end
  end

  assign bus.digits_out = r_digits;
  assign bus.dp_out     = r_dp;
  assign bus.valid_out  = r_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Drives one logical stimulus into an active-high and an active-low encoder (pins inverted).
// Expected outputs come from a run-length model of the readback rules, checked every cycle.
// Directed steps reproduce the named scenarios, then a randomized scan soak follows.
`timescale 1ns/1ps
module tb_seg_pattern_encoder;

  localparam int NDIG = 4;
  localparam int SC   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_pattern_encoder_if #(.NDIG(NDIG)) bus_h ();
  seg_pattern_encoder_if #(.NDIG(NDIG)) bus_l ();

  seg_pattern_encoder #(.NDIG(NDIG), .STABLE_CYC(SC), .SEG_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .bus(bus_h)
  );
  seg_pattern_encoder #(.NDIG(NDIG), .STABLE_CYC(SC), .SEG_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state (logical, lit=1 polarity).
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_val, m_seen;
  logic        m_fd, m_err;
  logic [11:0] m_last;
  int          m_run;
  bit          m_cap;

  int fd_cnt, err_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_idx(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_dig = '0; m_dp = '0; m_val = '0; m_seen = '0;
    m_fd = 1'b0; m_err = 1'b0;
    m_last = '0; m_run = 1; m_cap = 1'b0;
  endtask

  // One clock edge: apply a capture pending from a completed run, then account the new sample.
  task automatic model_edge(input logic [3:0] an, input logic [7:0] s);
    logic [3:0] cm;
    logic [3:0] ca;
    logic [7:0] cs;
    bit         full;
    int         d, g;
    cm   = '0;
    full = (m_seen == 4'hF);
    m_err = 1'b0;
    if (m_cap) begin
      ca = m_last[11:8];
      cs = m_last[7:0];
      if ($countones(ca) > 1) begin
        m_err = 1'b1;
      end else if ($countones(ca) == 1) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (ca[i]) d = i;
        cm[d] = 1'b1;
        g = glyph_idx(cs[6:0]);
        if (g >= 0) begin
          m_dig[4*d +: 4] = 4'(g);
          m_dp[d]  = cs[7];
          m_val[d] = 1'b1;
        end else begin
          m_val[d] = 1'b0;
          if (cs[6:0] == 7'h00) m_dp[d] = cs[7];
          else m_err = 1'b1;
        end
      end
    end
    m_fd   = full;
    m_seen = full ? cm : (m_seen | cm);
    if ({an, s} == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run  = 1;
      m_last = {an, s};
    end
    m_cap = (m_run == SC);
  endtask

  task automatic check_all();
    chk("h_digits", 32'(bus_h.digits_out), 32'(m_dig));
    chk("h_dp",     32'(bus_h.dp_out),     32'(m_dp));
    chk("h_valid",  32'(bus_h.valid_out),  32'(m_val));
    chk("h_fd",     32'(bus_h.frame_done), 32'(m_fd));
    chk("h_err",    32'(bus_h.err),        32'(m_err));
    chk("l_digits", 32'(bus_l.digits_out), 32'(m_dig));
    chk("l_dp",     32'(bus_l.dp_out),     32'(m_dp));
    chk("l_valid",  32'(bus_l.valid_out),  32'(m_val));
    chk("l_fd",     32'(bus_l.frame_done), 32'(m_fd));
    chk("l_err",    32'(bus_l.err),        32'(m_err));
  endtask

  // Called just after a falling edge: drive pins, let one rising edge pass, check at the next fall.
  task automatic cyc(input logic [3:0] an, input logic [7:0] s);
    bus_h.an  = an;
    bus_h.seg = s;
    bus_l.an  = an;
    bus_l.seg = ~s;
    @(posedge clk);
    model_edge(an, s);
    @(negedge clk);
    check_all();
    fd_cnt  += int'(bus_h.frame_done);
    err_cnt += int'(bus_h.err);
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) cyc(an, s);
  endtask

  // Reset held for n cycles with bus activity; everything must stay cleared.
  task automatic reset_phase(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < n; k++) begin
      bus_h.an  = 4'($urandom);
      bus_h.seg = 8'($urandom);
      bus_l.an  = bus_h.an;
      bus_l.seg = ~bus_h.seg;
      @(negedge clk);
      check_all();
    end
    bus_h.an = '0; bus_h.seg = '0; bus_l.an = '0; bus_l.seg = 8'hFF;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] rs;
    int         pick, len;

    bus_h.an = '0; bus_h.seg = '0; bus_l.an = '0; bus_l.seg = 8'hFF;
    model_reset();

    // Reset with activity, then quiet cycles with no pulses.
    @(negedge clk);
    reset_phase(5);
    fd_cnt = 0; err_cnt = 0;
    hold(4'b0000, 8'h00, 6);
    chk("rst_no_pulse", 32'(fd_cnt + err_cnt), 32'd0);

    // Single digit: capture lands exactly SC edges after the first sample.
    hold(4'b0001, 8'h5B, 4);
    chk("lat_not_yet", 32'(bus_h.valid_out), 32'h0);
    cyc(4'b0001, 8'h5B);
    chk("lat_digit0", 32'(bus_h.digits_out[3:0]), 32'h2);
    chk("lat_valid",  32'(bus_h.valid_out),       32'h1);
    hold(4'b0001, 8'h5B, 6);

    // Two full scans, one frame pulse per scan.
    fd_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) hold(4'(1 << d), {1'b0, glyph[d]}, 6);
      chk("scan_digits", 32'(bus_h.digits_out), 32'h3210);
      chk("scan_valid",  32'(bus_h.valid_out),  32'hF);
      chk("scan_fd_cnt", 32'(fd_cnt), 32'(r + 1));
    end

    // Short glitch never captured.
    err_cnt = 0;
    hold(4'b0010, 8'h66, 3);
    hold(4'b0010, 8'h6D, 4);
    cyc(4'b0000, 8'h00);
    chk("glitch_digit1", 32'(bus_h.digits_out[7:4]), 32'h5);
    chk("glitch_no_err", 32'(err_cnt), 32'd0);

    // Illegal glyph, then multi-hot select.
    err_cnt = 0;
    hold(4'b0100, 8'h55, 6);
    chk("illegal_err",    32'(err_cnt), 32'd1);
    chk("illegal_valid2", 32'(bus_h.valid_out[2]), 32'd0);
    chk("illegal_keep2",  32'(bus_h.digits_out[11:8]), 32'h2);
    hold(4'b0110, 8'h3F, 6);
    chk("multi_err",    32'(err_cnt), 32'd2);
    chk("multi_digits", 32'(bus_h.digits_out), 32'h3250);

    // Glyph with dp on digit 3; the active-low instance sees ~8'h86.
    hold(4'b1000, 8'h86, 6);
    chk("al_digit3", 32'(bus_l.digits_out[15:12]), 32'h1);
    chk("al_dp3",    32'(bus_l.dp_out[3]),         32'd1);
    chk("al_valid3", 32'(bus_l.valid_out[3]),      32'd1);

    // Blank slot with dp loads dp only.
    hold(4'b0001, 8'h80, 6);
    chk("blank_dp0",    32'(bus_h.dp_out[0]),    32'd1);
    chk("blank_valid0", 32'(bus_h.valid_out[0]), 32'd0);

    // Asynchronous reset in the middle of a count.
    hold(4'b0100, 8'h4F, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_digits", 32'(bus_h.digits_out), 32'h0);
    chk("async_valid",  32'(bus_h.valid_out | bus_l.valid_out), 32'h0);
    @(negedge clk);
    reset_phase(2);

    // Randomized scan soak.
    for (int t = 0; t < 400; t++) begin
      pick = int'($urandom_range(0, 9));
      ra   = 4'(1 << $urandom_range(0, 3));
      rs   = {1'($urandom), glyph[$urandom_range(0, 15)]};
      if (pick == 0) ra = 4'b0000;
      else if (pick == 1) ra = 4'($urandom);
      if (pick == 2) rs = 8'($urandom);
      else if (pick == 3) rs = {1'($urandom), 7'h00};
      len = int'($urandom_range(1, 7));
      hold(ra, rs, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
